// File: rtl/rcv_pkg.sv
// Shared types for the serial packet receive controller.
// State encoding and default sync byte.
package rcv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC_WAIT,
    SYNC_CHK,
    RECEIVE,
    STORE,
    ERR_EOP,
    EOP_WAIT
  } rcv_state_t;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'h80;

endpackage

// File: rtl/bit_slot_counter.sv
// Counts sample strobes within one byte slot.
// rollover_o flags the strobe that completes the slot.
module bit_slot_counter #(
  parameter int N  = 8,
  parameter int CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          clear_i,
  input  logic          count_en_i,
  output logic [CW-1:0] count_o,
  output logic          rollover_o
);

  logic [CW-1:0] count_q, count_d;

  assign rollover_o = count_en_i &&
                      (count_q == CW'(N - 1));
  assign count_o    = count_q;

  always_comb begin
    count_d = count_q;
    if (clear_i)
      count_d = '0;
    else if (rollover_o)
      count_d = '0;
    else if (count_en_i)
      count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) count_q <= '0;
    else        count_q <= count_d;
  end

endmodule

// File: rtl/rcv_ctrl_fsm.sv
// Receive control FSM: sync check, byte framing,
// FIFO write pulses and sticky framing error.
module rcv_ctrl_fsm
  import rcv_pkg::*;
#(
  parameter int         BITS_PER_BYTE = 8,
  parameter logic [7:0] SYNC_BYTE     = SYNC_BYTE_DEF,
  parameter int         MAX_BYTES     = 64,
  parameter int         BCW           = 7
) (
  input  logic           clk,
  input  logic           n_rst,
  input  logic           d_edge,
  input  logic           shift_strobe,
  input  logic           eop,
  input  logic [7:0]     rcv_data,
  output logic           rcving,
  output logic           w_enable,
  output logic           r_error,
  output logic [BCW-1:0] byte_count
);

  localparam int CW = $clog2(BITS_PER_BYTE + 1);

  rcv_state_t     state_q, state_d;
  logic [BCW-1:0] cnt_q, cnt_d;
  logic           err_q, err_d;
  logic [CW-1:0]  bit_cnt;
  logic           term;

  // Held clear in IDLE so every packet starts at slot 0.
  bit_slot_counter #(
    .N  (BITS_PER_BYTE),
    .CW (CW)
  ) u_bits (
    .clk        (clk),
    .n_rst      (n_rst),
    .clear_i    (state_q == IDLE),
    .count_en_i (shift_strobe),
    .count_o    (bit_cnt),
    .rollover_o (term)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (d_edge) begin
          state_d = SYNC_WAIT;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      SYNC_WAIT: begin
        if (eop)       state_d = ERR_EOP;
        else if (term) state_d = SYNC_CHK;
      end
      SYNC_CHK: begin
        state_d = (rcv_data == SYNC_BYTE) ?
                  RECEIVE : ERR_EOP;
      end
      RECEIVE: begin
        if (eop)
          state_d = (bit_cnt == '0) ?
                    EOP_WAIT : ERR_EOP;
        else if (term)
          state_d = STORE;
      end
      STORE: begin
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_d == BCW'(MAX_BYTES)) ?
                  ERR_EOP : RECEIVE;
      end
      ERR_EOP: begin
        if (eop) state_d = EOP_WAIT;
      end
      EOP_WAIT: begin
        if (!eop) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state_d == ERR_EOP) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign rcving     = (state_q != IDLE);
  assign w_enable   = (state_q == STORE);
  assign r_error    = err_q;
  assign byte_count = cnt_q;

endmodule

// File: tb/tb_rcv_ctrl_fsm.sv
// Self-checking bench for rcv_ctrl_fsm.
// Packet table plus hand sequences for corner cases.
module tb_rcv_ctrl_fsm;

  localparam int BCW = 7;

  logic           clk = 1'b0;
  logic           n_rst;
  logic           d_edge;
  logic           shift_strobe;
  logic           eop;
  logic [7:0]     rcv_data;
  logic           rcving;
  logic           w_enable;
  logic           r_error;
  logic [BCW-1:0] byte_count;

  rcv_ctrl_fsm #(
    .BITS_PER_BYTE (8),
    .SYNC_BYTE     (8'h80),
    .MAX_BYTES     (4),
    .BCW           (BCW)
  ) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .d_edge       (d_edge),
    .shift_strobe (shift_strobe),
    .eop          (eop),
    .rcv_data     (rcv_data),
    .rcving       (rcving),
    .w_enable     (w_enable),
    .r_error      (r_error),
    .byte_count   (byte_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] sync;
    int         nb;
    int         extra;
    int         exp_w;
    int         exp_cnt;
    bit         exp_err;
  } vec_t;

  vec_t       tbl[6];
  logic [7:0] pay[5];
  logic [7:0] wq[$];
  int         errors = 0;
  int         checks = 0;

  task automatic chk(input string nm,
                     input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  // Advance one clock; sample outputs 1 time unit after the edge.
  task automatic tick();
    logic [7:0] e;
    @(posedge clk);
    #1;
    d_edge       = 1'b0;
    shift_strobe = 1'b0;
    if (w_enable) begin
      checks++;
      if (wq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got data %02h expected none",
                 rcv_data);
      end else begin
        e = wq.pop_front();
        if (rcv_data != e) begin
          errors++;
          $display("FAIL write_data: got %02h expected %02h",
                   rcv_data, e);
        end
      end
    end
  endtask

  task automatic strobe();
    shift_strobe = 1'b1;
    tick();
    tick();
    tick();
  endtask

  task automatic send_byte(input logic [7:0] b,
                           input bit push);
    rcv_data = b;
    if (push) wq.push_back(b);
    for (int i = 0; i < 8; i++) strobe();
  endtask

  task automatic send_pkt(input vec_t v);
    d_edge = 1'b1;
    tick();
    chk({v.name, "_start_rcving"}, int'(rcving), 1);
    chk({v.name, "_start_err"}, int'(r_error), 0);
    chk({v.name, "_start_cnt"}, int'(byte_count), 0);
    send_byte(v.sync, 1'b0);
    for (int i = 0; i < v.nb; i++)
      send_byte(pay[i % 5], i < v.exp_w);
    for (int i = 0; i < v.extra; i++) strobe();
    eop = 1'b1;
    tick();
    tick();
    tick();
    chk({v.name, "_err"}, int'(r_error), int'(v.exp_err));
    chk({v.name, "_cnt"}, int'(byte_count), v.exp_cnt);
    chk({v.name, "_rcving"}, int'(rcving), 1);
    eop = 1'b0;
    tick();
    tick();
    chk({v.name, "_idle"}, int'(rcving), 0);
    chk({v.name, "_err_hold"}, int'(r_error), int'(v.exp_err));
    chk({v.name, "_cnt_hold"}, int'(byte_count), v.exp_cnt);
    chk({v.name, "_wq_empty"}, wq.size(), 0);
    tick();
  endtask

  initial begin
    pay[0] = 8'hA5; pay[1] = 8'h3C; pay[2] = 8'h5A;
    pay[3] = 8'hC3; pay[4] = 8'h0F;
    tbl[0] = '{"two_bytes",  8'h80, 2, 0, 2, 2, 1'b0};
    tbl[1] = '{"bad_sync",   8'h81, 1, 0, 0, 0, 1'b1};
    tbl[2] = '{"early_eop",  8'h80, 1, 5, 1, 1, 1'b1};
    tbl[3] = '{"max_bytes",  8'h80, 5, 0, 4, 4, 1'b1};
    tbl[4] = '{"three",      8'h80, 3, 0, 3, 3, 1'b0};
    tbl[5] = '{"sync_only",  8'h80, 0, 0, 0, 0, 1'b0};

    n_rst        = 1'b0;
    d_edge       = 1'b0;
    shift_strobe = 1'b0;
    eop          = 1'b0;
    rcv_data     = 8'h00;
    tick();
    tick();
    chk("rst_rcving", int'(rcving), 0);
    chk("rst_wen", int'(w_enable), 0);
    chk("rst_err", int'(r_error), 0);
    chk("rst_cnt", int'(byte_count), 0);
    n_rst = 1'b1;
    tick();

    for (int k = 0; k < 6; k++) send_pkt(tbl[k]);

    // eop wins over a simultaneous terminal strobe
    d_edge = 1'b1;
    tick();
    send_byte(8'h80, 1'b0);
    rcv_data = 8'hA5;
    for (int i = 0; i < 7; i++) strobe();
    eop          = 1'b1;
    shift_strobe = 1'b1;
    tick();
    chk("eop_vs_strobe_err", int'(r_error), 1);
    tick();
    tick();
    chk("eop_vs_strobe_cnt", int'(byte_count), 0);
    chk("eop_vs_strobe_wen", int'(w_enable), 0);
    eop = 1'b0;
    tick();
    tick();
    chk("eop_vs_strobe_idle", int'(rcving), 0);

    // eop while still waiting for the sync byte
    d_edge = 1'b1;
    tick();
    chk("sync_eop_clr", int'(r_error), 0);
    rcv_data = 8'h80;
    for (int i = 0; i < 3; i++) strobe();
    eop = 1'b1;
    tick();
    chk("sync_eop_err", int'(r_error), 1);
    tick();
    eop = 1'b0;
    tick();
    tick();
    chk("sync_eop_idle", int'(rcving), 0);

    // asynchronous reset in the middle of a payload byte
    d_edge = 1'b1;
    tick();
    send_byte(8'h80, 1'b0);
    send_byte(8'h3C, 1'b1);
    for (int i = 0; i < 3; i++) strobe();
    chk("pre_rst_cnt", int'(byte_count), 1);
    chk("pre_rst_rcving", int'(rcving), 1);
    #2;
    n_rst = 1'b0;
    #1;
    chk("mid_rst_rcving", int'(rcving), 0);
    chk("mid_rst_wen", int'(w_enable), 0);
    chk("mid_rst_err", int'(r_error), 0);
    chk("mid_rst_cnt", int'(byte_count), 0);
    tick();
    n_rst = 1'b1;
    tick();
    send_pkt('{"after_rst", 8'h80, 1, 0, 1, 1, 1'b0});

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
